cla_seq_ctrl: RTL and testbench

Multi-cycle add/subtract sequencer that reuses one CHUNK-bit carry-lookahead slice to process a WIDTH-bit operand pair, least significant chunk first, one chunk per clock. Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake. It sits between the ALU operand registers and the ALU result mux and trades latency for adder area.

---
 rtl/cla_seq_ctrl_pkg.sv | 13 +
 rtl/cla_seq_ctrl_chunk.sv | 56 +++++
 rtl/cla_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_cla_seq_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cla_seq_ctrl_pkg.sv
// Shared definitions for the chunked add/subtract sequencer: FSM encoding and default sizes.
package cla_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/cla_seq_ctrl_chunk.sv
// CHUNK-bit carry-lookahead slice built from full_adder cells; purely combinational.
// Also exposes the carry into its top bit so the caller can derive signed overflow.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic p,
   output logic g
);

   assign s = a ^ b ^ ci;
   assign p = a | b;
   assign g = a & b;

endmodule

module cla_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK-1:0] p;
   logic [CHUNK-1:0] g;
   logic [CHUNK:0]   c;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .p  (p[i]),
         .g  (g[i])
      );
   end

   // p = a|b is sufficient for the carry term; the sum bit uses a^b inside the cell.
   always_comb begin
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < CHUNK; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
   end

   assign co    = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Multi-cycle add/subtract: one CHUNK-bit lookahead slice reused LSB chunk first, one chunk per clock.
// Result valid NCHUNK+1 edges after accept; held in DONE until out_ready, no overlap of operations.
module cla_seq_ctrl
   import cla_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry;
   logic [IDXW-1:0]  idx;

   logic [CHUNK-1:0] a_chunks [NCHUNK];
   logic [CHUNK-1:0] b_chunks [NCHUNK];
   logic [CHUNK-1:0] a_cur;
   logic [CHUNK-1:0] b_cur;
   logic [CHUNK-1:0] s_cur;
   logic             co_cur;
   logic             cmsb_cur;

   for (genvar k = 0; k < NCHUNK; k++) begin : g_split
      assign a_chunks[k] = a_reg[k*CHUNK +: CHUNK];
      assign b_chunks[k] = b_reg[k*CHUNK +: CHUNK];
   end

   assign a_cur = a_chunks[idx];
   assign b_cur = b_chunks[idx];

   cla_chunk #(
      .CHUNK (CHUNK)
   ) u_slice (
      .a     (a_cur),
      .b     (b_cur),
      .ci    (carry),
      .s     (s_cur),
      .co    (co_cur),
      .c_msb (cmsb_cur)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         idx       <= '0;
         carry     <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  // Subtraction is A + ~B + 1, so the slice never needs to know the op.
                  a_reg    <= a;
                  b_reg    <= sub ? ~b : b;
                  carry    <= sub ? 1'b1 : cin;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               for (int k = 0; k < NCHUNK; k++) begin
                  if (idx == IDXW'(k)) begin
                     sum[k*CHUNK +: CHUNK] <= s_cur;
                  end
               end
               carry <= co_cur;
               if (idx == LAST_IDX) begin
                  cout  <= co_cur;
                  ovf   <= cmsb_cur ^ co_cur;
                  state <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               // First DONE cycle raises out_valid; handshake only once it is visible.
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for cla_seq_ctrl at WIDTH=8, CHUNK=4 with hand-computed results.
module tb_cla_seq_ctrl;

   localparam int WIDTH  = 8;
   localparam int CHUNK  = 4;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int n_chk  = 0;
   int n_pass = 0;

   cla_seq_ctrl #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic sv, input logic cv, input string tag);
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
      a        = av;
      b        = bv;
      sub      = sv;
      cin      = cv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(NCHUNK + 1));
   endtask

   task automatic run_op(input string tag,
                         input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic sv, input logic cv,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo);
      out_ready = 1'b1;
      start_op(av, bv, sv, cv, tag);
      wait_valid(tag);
      chk({tag, "_sum"},  32'(sum),  32'(es));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      chk({tag, "_ovf"},  32'(ovf),  32'(eo));
      tick();
      chk({tag, "_in_ready_after"},  32'(in_ready),  32'd1);
      chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      cin       = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum",       32'(sum),       32'd0);
      chk("rst_cout",      32'(cout),      32'd0);
      chk("rst_ovf",       32'(ovf),       32'd0);

      run_op("add_basic",  8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0);
      run_op("add_ripple", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
      run_op("add_ovf",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      run_op("sub_borrow", 8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
      run_op("sub_noborr", 8'h20, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
      run_op("sub_ovf",    8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

      // Backpressure: result must hold while a competing request is presented.
      out_ready = 1'b0;
      start_op(8'h12, 8'h34, 1'b0, 1'b0, "bp");
      wait_valid("bp");
      a        = 8'hFF;
      b        = 8'hFF;
      sub      = 1'b0;
      cin      = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("bp_out_valid_%0d", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp_sum_%0d", i),       32'(sum),       32'h46);
         chk($sformatf("bp_in_ready_%0d", i),  32'(in_ready),  32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_in_ready",  32'(in_ready),  32'd1);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      tick();
      chk("bp_not_accepted", 32'(in_ready), 32'd1);
      chk("bp_sum_kept",     32'(sum),      32'h46);

      // Reset asserted during the second RUN cycle.
      start_op(8'h55, 8'h22, 1'b0, 1'b0, "mid_rst");
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_sum",       32'(sum),       32'd0);
      chk("mid_rst_cout",      32'(cout),      32'd0);
      run_op("post_rst", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
